// File: rtl/cpu_ctrl_pkg.sv
// Shared opcodes, state encoding and default widths for the CPU run/load sequencer.
package cpu_ctrl_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;

    localparam logic [2:0] OP_NOP      = 3'd0;
    localparam logic [2:0] OP_SET_ADDR = 3'd1;
    localparam logic [2:0] OP_WRITE    = 3'd2;
    localparam logic [2:0] OP_RUN      = 3'd3;
    localparam logic [2:0] OP_STEP     = 3'd4;
    localparam logic [2:0] OP_HALT     = 3'd5;
    localparam logic [2:0] OP_CLR      = 3'd6;
    localparam logic [2:0] OP_RSVD     = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_e;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Command, CPU-control and program-memory write signals of the run/load sequencer.
interface cpu_run_ctrl_if
    import cpu_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [DATA_W-1:0] cmd_data;
    logic [ADDR_W-1:0] cpu_pc;
    logic              cpu_en;
    logic              cpu_clr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              busy;
    logic              cmd_err;
    logic [CNT_W-1:0]  instr_cnt;
    logic              bp_hit;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cpu_pc,
        input  cmd_ready, cpu_en, cpu_clr, mem_we, mem_waddr, mem_wdata,
               busy, cmd_err, instr_cnt, bp_hit
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cpu_pc,
        output cmd_ready, cpu_en, cpu_clr, mem_we, mem_waddr, mem_wdata,
               busy, cmd_err, instr_cnt, bp_hit
    );

endinterface

// File: rtl/cpu_step_counter.sv
// Down-counter for single/multi-step: load n, decrement while stepping, flag the last step.
module cpu_step_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    input  logic         i_clr,
    output logic         o_last
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_last = (r_cnt == W'(1));

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/load sequencer for the 8-bit accumulator CPU; breakpoint option: CPU_RUN_CTRL_BREAKPOINT_EN.
// state   | meaning
// ST_IDLE | CPU stalled, program memory writable
// ST_RUN  | free-running until HALT, CLR_CPU or breakpoint
// ST_STEP | CPU enabled for the loaded step count, then back to idle
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input logic           clk,
    input logic           rst_n,
    cpu_run_ctrl_if.slave bus
);

    state_e r_state, w_state_nxt;

    logic              w_acc, w_busy, w_cpu_en, w_bp_match, w_step_last;
    logic              w_run_ok, w_step_ok, w_write_ok, w_set_addr, w_reject, w_halt, w_clr;
    logic [ADDR_W-1:0] r_ptr, r_mem_waddr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_we, r_cmd_err, r_cpu_clr;
    logic [CNT_W-1:0]  r_instr_cnt;

    assign bus.cmd_ready = 1'b1;
    assign w_acc  = bus.cmd_valid & bus.cmd_ready;
    assign w_busy = (r_state != ST_IDLE);

    assign w_set_addr = w_acc && (bus.cmd_op == OP_SET_ADDR);
    assign w_write_ok = w_acc && (bus.cmd_op == OP_WRITE) && !w_busy;
    assign w_run_ok   = w_acc && (bus.cmd_op == OP_RUN) && !w_busy;
    assign w_step_ok  = w_acc && (bus.cmd_op == OP_STEP) && !w_busy && (bus.cmd_data != '0);
    assign w_halt     = w_acc && (bus.cmd_op == OP_HALT);
    assign w_clr      = w_acc && (bus.cmd_op == OP_CLR);
    assign w_reject   = w_acc && w_busy &&
                        ((bus.cmd_op == OP_WRITE) || (bus.cmd_op == OP_RUN) || (bus.cmd_op == OP_STEP));

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    logic [ADDR_W-1:0] r_bp_addr;
    logic              r_bp_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bp_addr <= '0;
            r_bp_hit  <= 1'b0;
        end else begin
            if (w_run_ok) begin
                r_bp_addr <= bus.cmd_data;
            end
            if (w_clr || w_run_ok) begin
                r_bp_hit <= 1'b0;
            end else if (w_bp_match) begin
                r_bp_hit <= 1'b1;
            end
        end
    end

    // The matching instruction must not retire, so the compare gates cpu_en in the same cycle.
    assign w_bp_match = (r_state == ST_RUN) && (bus.cpu_pc == r_bp_addr);
    assign bus.bp_hit = r_bp_hit;
`else
    logic w_unused_pc;
    assign w_unused_pc = ^bus.cpu_pc;
    assign w_bp_match  = 1'b0;
    assign bus.bp_hit  = 1'b0;
`endif

    cpu_step_counter #(.W(DATA_W)) u_step_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_step_ok),
        .i_load_val (bus.cmd_data),
        .i_dec      (r_state == ST_STEP),
        .i_clr      (w_clr | w_halt),
        .o_last     (w_step_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cpu_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_run_ok) begin
                    w_state_nxt = ST_RUN;
                end else if (w_step_ok) begin
                    w_state_nxt = ST_STEP;
                end
            end
            ST_RUN: begin
                w_cpu_en = !w_bp_match;
                if (w_bp_match || w_halt) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_STEP: begin
                w_cpu_en = 1'b1;
                if (w_step_last || w_halt) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_clr) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_waddr <= '0;
            r_mem_wdata <= '0;
            r_cmd_err   <= 1'b0;
            r_cpu_clr   <= 1'b0;
            r_instr_cnt <= '0;
        end else begin
            r_mem_we  <= w_write_ok;
            r_cmd_err <= w_reject;
            r_cpu_clr <= w_clr;
            if (w_write_ok) begin
                r_mem_waddr <= r_ptr;
                r_mem_wdata <= bus.cmd_data;
                r_ptr       <= r_ptr + ADDR_W'(1);
            end else if (w_set_addr) begin
                r_ptr <= bus.cmd_data;
            end
            if (w_clr) begin
                r_instr_cnt <= '0;
            end else if (w_cpu_en && (r_instr_cnt != {CNT_W{1'b1}})) begin
                r_instr_cnt <= r_instr_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.cpu_en    = w_cpu_en;
    assign bus.cpu_clr   = r_cpu_clr;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_waddr = r_mem_waddr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.busy      = w_busy;
    assign bus.cmd_err   = r_cmd_err;
    assign bus.instr_cnt = r_instr_cnt;

endmodule
